// File: rtl/i2c_tx_fifo.sv
// i2c_tx_fifo: 16-entry transmit byte FIFO between the APB register block and the I2C core.
// Define I2C_TX_FIFO_ERR_FLAGS_EN to add sticky overflow/underflow flags and err_clr_i.
module i2c_tx_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  pclk_i,
  input  logic                  preset_n_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  input  logic                  wr_en_i,
  input  logic                  rd_en_i,
  output logic [DATA_WIDTH-1:0] rd_data_o,
  output logic                  rd_valid_o,
  output logic                  full_o,
  output logic                  empty_o,
`ifdef I2C_TX_FIFO_ERR_FLAGS_EN
  output logic                  overflow_o,
  output logic                  underflow_o,
  input  logic                  err_clr_i,
`endif
  output logic [ADDR_WIDTH:0]   count_o
);
  logic [DATA_WIDTH-1:0] r_mem [2**ADDR_WIDTH];
  logic [ADDR_WIDTH:0]   r_wr_ptr, r_rd_ptr;
  logic                  r_wr_en_q;
  logic                  w_wr_stb, w_wr_acc, w_rd_acc;
  // wr_en_i is a level held for the whole APB access; only its rising edge writes
  assign w_wr_stb = wr_en_i & ~r_wr_en_q;
  assign full_o   = (r_wr_ptr[ADDR_WIDTH] != r_rd_ptr[ADDR_WIDTH]) &&
                    (r_wr_ptr[ADDR_WIDTH-1:0] == r_rd_ptr[ADDR_WIDTH-1:0]);
  assign empty_o  = r_wr_ptr == r_rd_ptr;
  assign count_o  = r_wr_ptr - r_rd_ptr;
  assign w_wr_acc = w_wr_stb & ~full_o;
  assign w_rd_acc = rd_en_i & ~empty_o;
  always_ff @(posedge pclk_i or negedge preset_n_i) begin
    if (!preset_n_i) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_wr_en_q  <= 1'b0;
      rd_data_o  <= '0;
      rd_valid_o <= 1'b0;
    end else begin
      r_wr_en_q  <= wr_en_i;
      rd_valid_o <= w_rd_acc;
      if (w_wr_acc) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_rd_acc) begin
        r_rd_ptr  <= r_rd_ptr + 1'b1;
        rd_data_o <= r_mem[r_rd_ptr[ADDR_WIDTH-1:0]];
      end
    end
  end
  // storage is deliberately left out of reset
  always_ff @(posedge pclk_i)
    if (w_wr_acc) r_mem[r_wr_ptr[ADDR_WIDTH-1:0]] <= wr_data_i;
`ifdef I2C_TX_FIFO_ERR_FLAGS_EN
  always_ff @(posedge pclk_i or negedge preset_n_i) begin
    if (!preset_n_i) begin
      overflow_o  <= 1'b0;
      underflow_o <= 1'b0;
    end else begin
      overflow_o  <= (w_wr_stb & full_o) ? 1'b1 : err_clr_i ? 1'b0 : overflow_o;
      underflow_o <= (rd_en_i & empty_o) ? 1'b1 : err_clr_i ? 1'b0 : underflow_o;
    end
  end
`endif
endmodule

// File: tb/tb_i2c_tx_fifo.sv
// tb_i2c_tx_fifo: scoreboard bench; stimulus pushes expected read bytes, a monitor pops them on rd_valid_o.
module tb_i2c_tx_fifo;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] wr_data = '0;
  logic       wr_en = 1'b0;
  logic       rd_en = 1'b0;
  logic [7:0] rd_data;
  logic       rd_valid, full, empty;
  logic [4:0] count;
`ifdef I2C_TX_FIFO_ERR_FLAGS_EN
  logic       overflow, underflow;
  logic       err_clr = 1'b0;
`endif
  int         total = 0;
  int         passed = 0;
  logic [7:0] model [$];
  logic [7:0] exp_q [$];

  i2c_tx_fifo dut (
    .pclk_i(clk), .preset_n_i(rst_n), .wr_data_i(wr_data), .wr_en_i(wr_en), .rd_en_i(rd_en),
    .rd_data_o(rd_data), .rd_valid_o(rd_valid), .full_o(full), .empty_o(empty),
`ifdef I2C_TX_FIFO_ERR_FLAGS_EN
    .overflow_o(overflow), .underflow_o(underflow), .err_clr_i(err_clr),
`endif
    .count_o(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  always @(posedge clk) begin
    logic [7:0] e;
    #1;
    if (rd_valid === 1'b1) begin
      if (exp_q.size() == 0) chk("spurious_rd_valid", 32'd1, 32'd0);
      else begin
        e = exp_q.pop_front();
        chk("rd_data", {24'd0, rd_data}, {24'd0, e});
      end
    end
  end

  task automatic check_flags(input string nm);
    chk({nm, "_count"}, {27'd0, count}, model.size());
    chk({nm, "_empty"}, {31'd0, empty}, {31'd0, model.size() == 0});
    chk({nm, "_full"},  {31'd0, full},  {31'd0, model.size() == 16});
  endtask

  task automatic wr_byte(input logic [7:0] d);
    @(negedge clk);
    wr_data = d;
    wr_en = 1'b1;
    if (model.size() < 16) model.push_back(d);
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic rd_pulse();
    @(negedge clk);
    rd_en = 1'b1;
    if (model.size() > 0) exp_q.push_back(model.pop_front());
    @(negedge clk);
    rd_en = 1'b0;
    chk("rd_latency", exp_q.size(), 32'd0);
  endtask

  task automatic wr_rd_same(input logic [7:0] d);
    bit was_full;
    @(negedge clk);
    wr_data = d;
    wr_en = 1'b1;
    rd_en = 1'b1;
    was_full = model.size() == 16;
    if (model.size() > 0) exp_q.push_back(model.pop_front());
    if (!was_full) model.push_back(d);
    @(negedge clk);
    wr_en = 1'b0;
    rd_en = 1'b0;
  endtask

  initial begin
    #1;
    chk("async_reset_count", {27'd0, count}, 32'd0);
    chk("reset_empty", {31'd0, empty}, 32'd1);
    chk("reset_full", {31'd0, full}, 32'd0);
    chk("reset_rd_valid", {31'd0, rd_valid}, 32'd0);
    chk("reset_rd_data", {24'd0, rd_data}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    // level held 5 cycles writes once
    @(negedge clk);
    wr_data = 8'hA5;
    wr_en = 1'b1;
    model.push_back(8'hA5);
    repeat (5) @(negedge clk);
    wr_en = 1'b0;
    @(negedge clk);
    check_flags("hold");
    rd_pulse();
    check_flags("hold_drain");
    for (int i = 1; i <= 16; i++) wr_byte(8'(i));
    check_flags("fill");
    wr_byte(8'hFF);
    check_flags("overflow_drop");
`ifdef I2C_TX_FIFO_ERR_FLAGS_EN
    chk("overflow_flag", {31'd0, overflow}, 32'd1);
    chk("underflow_clear", {31'd0, underflow}, 32'd0);
`endif
    for (int i = 0; i < 16; i++) rd_pulse();
    check_flags("drain");
    rd_pulse();
    check_flags("read_empty");
`ifdef I2C_TX_FIFO_ERR_FLAGS_EN
    chk("underflow_flag", {31'd0, underflow}, 32'd1);
    @(negedge clk);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    chk("err_clr_ovf", {31'd0, overflow}, 32'd0);
    chk("err_clr_udf", {31'd0, underflow}, 32'd0);
`endif
    wr_rd_same(8'h77);
    check_flags("same_cycle_empty");
    wr_byte(8'h11);
    wr_byte(8'h22);
    check_flags("pre_same");
    wr_rd_same(8'h3C);
    check_flags("same_cycle");
    for (int i = 0; i < 3; i++) rd_pulse();
    check_flags("same_drain");
    for (int b = 0; b < 4; b++) begin
      for (int i = 0; i < 10; i++) wr_byte(8'(8'h40 + b * 10 + i));
      check_flags("wrap_fill");
      for (int i = 0; i < 10; i++) rd_pulse();
      check_flags("wrap_drain");
    end
    for (int i = 0; i < 8; i++) wr_byte(8'(8'hC0 + i));
    @(negedge clk);
    rd_en = 1'b1;
    exp_q.push_back(model.pop_front());
    @(posedge clk);
    #2;
    chk("pre_reset_count", {27'd0, count}, 32'd7);
    chk("pre_reset_valid", {31'd0, rd_valid}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_reset_count", {27'd0, count}, 32'd0);
    chk("mid_reset_empty", {31'd0, empty}, 32'd1);
    chk("mid_reset_valid", {31'd0, rd_valid}, 32'd0);
    model.delete();
    rd_en = 1'b0;
    @(negedge clk);
    wr_data = 8'h5A;
    wr_en = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    model.push_back(8'h5A);
    @(negedge clk);
    wr_en = 1'b0;
    check_flags("post_reset_edge");
    rd_pulse();
    check_flags("final");
    repeat (3) @(negedge clk);
    chk("scoreboard_empty", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
